sc_reco_ed_frame: RTL and testbench

- Parametrised, frame-based stochastic-computing Roberts-cross edge detector for NPIX pixels in parallel.
- Each pixel takes four blurred SC bitstreams. The diagonal pairs (x0,x3) and (x1,x2) are optionally re-correlated by saturating synchronizers, then XOR-combined under a shared select stream c.
- The output ones are counted over a programmable stream length, giving a binary edge magnitude per pixel.
- Sits after the gb4 blur stage. Replaces the fixed single-pixel reco+rced path with run-time bypass, frame control and on-chip accumulation.

---
 rtl/sc_reco_ed_frame_if.sv | 25 ++
 rtl/sc_reco_ed_frame.sv | 187 ++++++++++++++++++
 tb/tb_sc_reco_ed_frame.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_reco_ed_frame_if.sv
// Bus bundle for the frame-based SC Roberts-cross edge detector.
interface sc_reco_ed_frame_if #(
  parameter int unsigned NPIX  = 1,
  parameter int unsigned LEN_W = 8
);
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    reco_en;
  logic                    c;
  logic [4*NPIX-1:0]       x;
  logic [NPIX-1:0]         z;
  logic                    busy;
  logic                    done;
  logic [NPIX*LEN_W-1:0]   cnt;

  modport master (
    output start, len, reco_en, c, x,
    input  z, busy, done, cnt
  );

  modport slave (
    input  start, len, reco_en, c, x,
    output z, busy, done, cnt
  );
endinterface

// File: rtl/sc_reco_ed_frame.sv
// Frame-based stochastic-computing Roberts-cross edge detector.
// Per pixel: two saturating re-correlators on the diagonal pairs, an XOR
// edge bit muxed by the shared select stream, and a ones counter over a
// programmable stream length.
module sc_reco_ed_frame #(
  parameter int unsigned NPIX  = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input logic                clk,
  input logic                rst,
  sc_reco_ed_frame_if.slave  bus
);

  // Signed synchronizer state wide enough for [-DEPTH, DEPTH] plus headroom.
  localparam int unsigned S_W = $clog2(DEPTH + 1) + 2;

  localparam logic signed [S_W-1:0] S_ZERO = '0;
  localparam logic signed [S_W-1:0] S_ONE  = S_W'(1);
  localparam logic signed [S_W-1:0] S_MAX  = S_W'(DEPTH);
  localparam logic signed [S_W-1:0] S_MIN  = -S_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [LEN_W-1:0]              rem_q, rem_d;
  logic                          reco_q, reco_d;
  logic [NPIX-1:0][S_W-1:0]      sa_q, sa_d;
  logic [NPIX-1:0][S_W-1:0]      sb_q, sb_d;
  logic [NPIX-1:0][1:0]          ya_q, ya_d;
  logic [NPIX-1:0][1:0]          yb_q, yb_d;
  logic                          cd_q, cd_d;
  logic                          valid_q, valid_d;
  logic [NPIX-1:0][LEN_W-1:0]    cnt_q, cnt_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [NPIX-1:0]               z_c;

  // One synchronizer step: returns {out_a, out_b, s_next}.
  function automatic logic [S_W+1:0] sync_step(
    input logic                  a,
    input logic                  b,
    input logic signed [S_W-1:0] s
  );
    logic                  oa;
    logic                  ob;
    logic signed [S_W-1:0] sn;
    oa = a;
    ob = b;
    sn = s;
    if (a && !b) begin
      if (s < S_ZERO) begin
        oa = 1'b1;
        ob = 1'b1;
        sn = s + S_ONE;
      end else if (s < S_MAX) begin
        oa = 1'b0;
        ob = 1'b0;
        sn = s + S_ONE;
      end
    end else if (!a && b) begin
      if (s > S_ZERO) begin
        oa = 1'b1;
        ob = 1'b1;
        sn = s - S_ONE;
      end else if (s > S_MIN) begin
        oa = 1'b0;
        ob = 1'b0;
        sn = s - S_ONE;
      end
    end
    return {oa, ob, sn};
  endfunction

  // Edge bit from the registered pair outputs; zero when no valid sample.
  always_comb begin
    z_c = '0;
    for (int p = 0; p < NPIX; p++) begin
      z_c[p] = valid_q & (cd_q ? (ya_q[p][1] ^ ya_q[p][0])
                               : (yb_q[p][1] ^ yb_q[p][0]));
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    reco_d  = reco_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ya_d    = ya_q;
    yb_d    = yb_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    valid_d = (state_q == RUN);

    // Accumulate the sample registered in the previous RUN cycle.
    if (valid_q) begin
      for (int p = 0; p < NPIX; p++) begin
        cnt_d[p] = cnt_q[p] + LEN_W'(z_c[p]);
      end
    end

    // Sample inputs through the synchronizers while running.
    if (state_q == RUN) begin
      cd_d = bus.c;
      for (int p = 0; p < NPIX; p++) begin
        if (reco_q) begin
          {ya_d[p], sa_d[p]} = sync_step(bus.x[4*p+0], bus.x[4*p+3], sa_q[p]);
          {yb_d[p], sb_d[p]} = sync_step(bus.x[4*p+1], bus.x[4*p+2], sb_q[p]);
        end else begin
          ya_d[p] = {bus.x[4*p+0], bus.x[4*p+3]};
          yb_d[p] = {bus.x[4*p+1], bus.x[4*p+2]};
          sa_d[p] = '0;
          sb_d[p] = '0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d   = bus.len;
          reco_d  = bus.reco_en;
          cnt_d   = '0;
          sa_d    = '0;
          sb_d    = '0;
          state_d = (bus.len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      reco_q  <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      ya_q    <= '0;
      yb_q    <= '0;
      cd_q    <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      reco_q  <= reco_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ya_q    <= ya_d;
      yb_q    <= yb_d;
      cd_q    <= cd_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.z    = z_c;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_sc_reco_ed_frame.sv
// Scoreboard bench for sc_reco_ed_frame: driver pushes expected frame
// timing, counts and per-cycle edge bits; a negedge monitor pops and compares.
module tb_sc_reco_ed_frame;
  localparam int unsigned NPIX  = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned XW    = 4 * NPIX;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sc_reco_ed_frame_if #(.NPIX(NPIX), .LEN_W(LEN_W)) bif();

  sc_reco_ed_frame #(.NPIX(NPIX), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct packed {
    int                     t;
    int                     l;
    logic [NPIX*LEN_W-1:0]  cnt;
  } frame_t;

  typedef struct packed {
    int              t;
    logic [NPIX-1:0] z;
  } zexp_t;

  frame_t fq[$];
  zexp_t  zq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   in_rst = 1'b1;

  logic [XW-1:0] xs_buf [256];
  logic          cs_buf [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Behavioural synchronizer: token count s with saturation at +-DEPTH.
  function automatic void sync_model(input bit a, input bit b, input bit en,
                                     inout int s, output bit oa, output bit ob);
    int d;
    d = DEPTH;
    oa = a;
    ob = b;
    if (!en) begin
      s = 0;
    end else if (a && !b) begin
      if (s < 0)      begin oa = 1; ob = 1; s = s + 1; end
      else if (s < d) begin oa = 0; ob = 0; s = s + 1; end
    end else if (!a && b) begin
      if (s > 0)       begin oa = 1; ob = 1; s = s - 1; end
      else if (s > -d) begin oa = 0; ob = 0; s = s - 1; end
    end
  endfunction

  // Monitor: frame timing, final counts and edge bits.
  logic            m_busy, m_done;
  logic [NPIX-1:0] m_z;
  always @(negedge clk) begin
    if (!in_rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      if (fq.size() > 0) begin
        m_busy = (cyc >= fq[0].t + 1) && (cyc <= fq[0].t + fq[0].l + 1);
        m_done = (cyc == fq[0].t + fq[0].l + 2);
      end
      chk("busy", 64'(bif.busy), 64'(m_busy));
      chk("done", 64'(bif.done), 64'(m_done));
      if (m_done) begin
        chk("cnt", 64'(bif.cnt), 64'(fq[0].cnt));
        void'(fq.pop_front());
      end
      m_z = '0;
      if (zq.size() > 0 && zq[0].t == cyc) begin
        m_z = zq[0].z;
        void'(zq.pop_front());
      end
      chk("z", 64'(bif.z), 64'(m_z));
    end
  end

  task automatic fill_rand(input int l);
    for (int i = 0; i < l; i++) begin
      xs_buf[i] = XW'($urandom);
      cs_buf[i] = 1'($urandom);
    end
  endtask

  // Push the model's expectations for a frame starting in cycle t.
  task automatic model_frame(input int t, input int l, input bit reco);
    int sa [NPIX];
    int sb [NPIX];
    int cm [NPIX];
    bit oa, ob, pa, pb;
    logic [NPIX-1:0] zv;
    frame_t f;
    for (int p = 0; p < NPIX; p++) begin sa[p] = 0; sb[p] = 0; cm[p] = 0; end
    for (int i = 0; i < l; i++) begin
      zv = '0;
      for (int p = 0; p < NPIX; p++) begin
        sync_model(xs_buf[i][4*p+0], xs_buf[i][4*p+3], reco, sa[p], oa, ob);
        sync_model(xs_buf[i][4*p+1], xs_buf[i][4*p+2], reco, sb[p], pa, pb);
        zv[p] = cs_buf[i] ? (oa ^ ob) : (pa ^ pb);
        cm[p] += int'(zv[p]);
      end
      zq.push_back('{t: t + 2 + i, z: zv});
    end
    f.t = t;
    f.l = l;
    f.cnt = '0;
    for (int p = 0; p < NPIX; p++) f.cnt[p*LEN_W +: LEN_W] = LEN_W'(cm[p]);
    fq.push_back(f);
  endtask

  // Drive one frame; called just after a posedge with the DUT idle.
  task automatic run_frame(input int l, input bit reco, input bit poke);
    model_frame(cyc, l, reco);
    bif.start   = 1'b1;
    bif.len     = LEN_W'(l);
    bif.reco_en = reco;
    bif.x       = XW'($urandom);
    @(posedge clk); #1;
    for (int i = 0; i < l; i++) begin
      bif.x     = xs_buf[i];
      bif.c     = cs_buf[i];
      bif.start = poke;
      bif.len   = LEN_W'($urandom);
      bif.reco_en = 1'($urandom);
      @(posedge clk); #1;
    end
    bif.x = XW'($urandom);
    bif.c = 1'($urandom);
    bif.start = poke;
    @(posedge clk); #1;
    bif.start = poke;
    @(posedge clk); #1;
    bif.start = 1'b0;
  endtask

  task automatic chk_pix(input string nm, input int p, input int v);
    chk(nm, 64'(bif.cnt[p*LEN_W +: LEN_W]), 64'(v));
  endtask

  initial begin
    int l;
    bit a;
    rst = 1'b1;
    bif.start = 1'b0;
    bif.len = '0;
    bif.reco_en = 1'b0;
    bif.c = 1'b0;
    bif.x = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_rst = 1'b0;
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_done", 64'(bif.done), 64'd0);
    chk("rst_cnt", 64'(bif.cnt), 64'd0);
    chk("rst_z", 64'(bif.z), 64'd0);
    @(posedge clk); #1;

    // Bypass: x0=1, x3=0, c=1 on pixel 0.
    fill_rand(16);
    for (int i = 0; i < 16; i++) begin
      xs_buf[i][0] = 1'b1; xs_buf[i][3] = 1'b0; cs_buf[i] = 1'b1;
    end
    run_frame(16, 1'b0, 1'b0);
    chk_pix("bypass_cnt", 0, 16);

    // Recorrelation of anti-correlated pair 0, then the same in bypass.
    fill_rand(16);
    for (int i = 0; i < 16; i++) begin
      xs_buf[i][0] = (i % 2 == 0); xs_buf[i][3] = (i % 2 != 0); cs_buf[i] = 1'b1;
    end
    run_frame(16, 1'b1, 1'b0);
    chk_pix("reco_cnt", 0, 0);
    run_frame(16, 1'b0, 1'b0);
    chk_pix("reco_byp_cnt", 0, 16);

    // Saturation, twice to show the state is cleared at start.
    fill_rand(8);
    for (int i = 0; i < 8; i++) begin
      xs_buf[i][0] = 1'b1; xs_buf[i][3] = 1'b0; cs_buf[i] = 1'b1;
    end
    run_frame(8, 1'b1, 1'b0);
    chk_pix("sat_cnt1", 0, 6);
    run_frame(8, 1'b1, 1'b0);
    chk_pix("sat_cnt2", 0, 6);

    // Zero length frame.
    run_frame(0, 1'b1, 1'b0);
    chk("len0_cnt", 64'(bif.cnt), 64'd0);

    // start held high through RUN, DRAIN and DONE.
    fill_rand(12);
    run_frame(12, 1'b1, 1'b1);

    // Multi-pixel c selection, c = 1100 repeating.
    for (int i = 0; i < 20; i++) begin
      xs_buf[i] = XW'($urandom);
      cs_buf[i] = ((i % 4) < 2);
      for (int p = 0; p < NPIX; p++) begin
        a = 1'($urandom);
        xs_buf[i][4*p+0] = a;
        xs_buf[i][4*p+3] = a ^ ((p == 0) || (p == 1));
        a = 1'($urandom);
        xs_buf[i][4*p+1] = a;
        xs_buf[i][4*p+2] = a ^ ((p == 1) || (p == 3));
      end
    end
    run_frame(20, 1'b0, 1'b0);
    chk_pix("mp_cnt0", 0, 10);
    chk_pix("mp_cnt1", 1, 20);
    chk_pix("mp_cnt2", 2, 0);
    chk_pix("mp_cnt3", 3, 10);

    // Reset in the fifth RUN cycle aborts the frame.
    fill_rand(16);
    model_frame(cyc, 16, 1'b1);
    bif.start = 1'b1;
    bif.len = LEN_W'(16);
    bif.reco_en = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bif.x = xs_buf[i]; bif.c = cs_buf[i];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    in_rst = 1'b1;
    fq.delete();
    zq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    in_rst = 1'b0;
    chk("abort_busy", 64'(bif.busy), 64'd0);
    chk("abort_cnt", 64'(bif.cnt), 64'd0);
    chk("abort_z", 64'(bif.z), 64'd0);
    chk("abort_done", 64'(bif.done), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    fill_rand(16);
    run_frame(16, 1'b1, 1'b0);

    // Random frames, including maximum length.
    for (int k = 0; k < 20; k++) begin
      l = (k == 7) ? 255 : int'($urandom_range(0, 40));
      fill_rand(l);
      run_frame(l, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_frames", 64'(fq.size()), 64'd0);
    chk("pending_z", 64'(zq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
